// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage. Owns the PC, fetches one instruction per retire over a
// req/valid handshake. Optional macro FETCH_MISALIGN_TRAP_EN traps on a misaligned next PC.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        retire,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] jal_target,
   input  logic [31:0] jalr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        misalign_trap,
   output logic [1:0]  state_dbg
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic [1:0] ST_TRAP = 2'd3;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [1:0]  state;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] next_pc;

   always_comb begin
      next_pc = pc_q + 32'd4;
      case (pc_src)
         2'b01:   if (branch_taken) next_pc = branch_target;
         2'b10:   next_pc = jal_target;
         2'b11:   next_pc = jalr_target & 32'hFFFF_FFFE;
         default: ;
      endcase
   end

   // Handshake: imem_req and imem_addr stay constant from the REQ entry until the cycle
   // imem_valid is seen high; imem_valid in any other state is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
      end else begin
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (imem_valid) begin
                  instr_q <= imem_rdata;
                  state   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (retire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                  // Faulting address is kept on pc for the trap handler.
                  pc_q  <= next_pc;
                  state <= (next_pc[1:0] != 2'b00) ? ST_TRAP : ST_REQ;
`else
                  pc_q  <= next_pc & 32'hFFFF_FFFC;
                  state <= ST_REQ;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_req    = (state == ST_REQ);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign instr       = instr_q;
   assign instr_valid = (state == ST_HOLD);
   assign state_dbg   = state;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign_trap = (state == ST_TRAP);
`else
   assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized fetch/retire sequences checked against a
// PC/next-PC reference model and an expected-instruction queue.
module tb_instr_fetch_unit;
   logic        clk;
   logic        rst_n;
   logic        retire;
   logic [1:0]  pc_src;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] jal_target;
   logic [31:0] jalr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic        instr_valid;
   logic        misalign_trap;
   logic [1:0]  state_dbg;

   int          total;
   int          bad;
   logic [31:0] m_pc;
   logic [31:0] last_instr;
   logic [31:0] exp_q[$];
   logic [31:0] amask;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .retire(retire), .pc_src(pc_src),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jal_target(jal_target), .jalr_target(jalr_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
      .instr_valid(instr_valid), .misalign_trap(misalign_trap), .state_dbg(state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] src,
                                              input logic tk, input logic [31:0] bt,
                                              input logic [31:0] jt, input logic [31:0] jrt);
      logic [31:0] t;
      case (src)
         2'd0:    t = cur + 32'd4;
         2'd1:    t = tk ? bt : cur + 32'd4;
         2'd2:    t = jt;
         default: t = {jrt[31:1], 1'b0};
      endcase
      return t;
   endfunction

   task automatic wait_req();
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      check("req_timeout", {31'b0, imem_req}, 32'd1);
   endtask

   // driver: memory side, answering after lat wait cycles
   task automatic fetch(input int lat, input logic [31:0] word, input bit poke_retire);
      wait_req();
      check("addr", imem_addr, m_pc);
      check("iv_in_req", {31'b0, instr_valid}, 32'd0);
      for (int k = 0; k < lat; k++) begin
         retire = poke_retire;
         pc_src = 2'($urandom_range(0, 3));
         tick();
         check("req_wait", {31'b0, imem_req}, 32'd1);
         check("addr_wait", imem_addr, m_pc);
         check("iv_wait", {31'b0, instr_valid}, 32'd0);
         check("pc_wait", pc, m_pc);
      end
      retire = 1'b0;
      imem_valid = 1'b1;
      imem_rdata = word;
      exp_q.push_back(word);
      tick();
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      last_instr = exp_q.pop_front();
      check("iv", {31'b0, instr_valid}, 32'd1);
      check("req_off", {31'b0, imem_req}, 32'd0);
      check("instr", instr, last_instr);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
   endtask

   // driver: core side; returns 1 when the model expects a misalign trap
   task automatic do_retire(input logic [1:0] src, input logic tk, input logic [31:0] bt,
                            input logic [31:0] jt, input logic [31:0] jrt, output bit trapped);
      logic [31:0] t;
      trapped = 1'b0;
      imem_valid = 1'b1;
      imem_rdata = 32'hBAD0_0BAD;
      tick();
      imem_valid = 1'b0;
      check("valid_in_hold", instr, last_instr);
      pc_src = src;
      branch_taken = tk;
      branch_target = bt;
      jal_target = jt;
      jalr_target = jrt;
      retire = 1'b1;
      t = model_next(m_pc, src, tk, bt, jt, jrt);
      tick();
      retire = 1'b0;
      branch_target = $urandom;
      jal_target = $urandom;
      jalr_target = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc = t;
      if (t[1:0] != 2'b00) begin
         trapped = 1'b1;
         check("trap", {31'b0, misalign_trap}, 32'd1);
         check("trap_pc", pc, t);
         check("trap_req", {31'b0, imem_req}, 32'd0);
         check("trap_iv", {31'b0, instr_valid}, 32'd0);
      end
`else
      m_pc = {t[31:2], 2'b00};
      check("no_trap", {31'b0, misalign_trap}, 32'd0);
`endif
   endtask

   initial begin
      bit tr;
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      retire = 1'b0;
      pc_src = 2'd0;
      branch_taken = 1'b0;
      branch_target = 32'd0;
      jal_target = 32'd0;
      jalr_target = 32'd0;
      imem_valid = 1'b0;
      imem_rdata = 32'd0;
      m_pc = 32'd0;
      last_instr = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
      amask = 32'hFFFF_FFFC;
`else
      amask = 32'hFFFF_FFFF;
`endif
      repeat (2) tick();

      // reset state
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_iv", {31'b0, instr_valid}, 32'd0);
      check("rst_trap", {31'b0, misalign_trap}, 32'd0);

      // first fetch: req rises after one clk, answered next cycle
      rst_n = 1'b1;
      check("idle_req", {31'b0, imem_req}, 32'd0);
      tick();
      check("first_req", {31'b0, imem_req}, 32'd1);
      fetch(0, 32'h0000_0093, 1'b0);

      // sequential, branch not taken / taken
      for (int i = 0; i < 3; i++) begin
         do_retire(2'd0, 1'b0, 32'd0, 32'd0, 32'd0, tr);
         fetch(0, $urandom, 1'b0);
      end
      do_retire(2'd1, 1'b0, 32'h0000_0080, 32'd0, 32'd0, tr);
      check("bnt_pc", m_pc, 32'h10);
      fetch(0, $urandom, 1'b0);
      do_retire(2'd1, 1'b1, 32'h0000_0040, 32'd0, 32'd0, tr);
      fetch(0, $urandom, 1'b0);

      // jalr clears bit0, jal
      do_retire(2'd3, 1'b0, 32'd0, 32'd0, 32'h0000_0101, tr);
      fetch(1, $urandom, 1'b0);
      do_retire(2'd2, 1'b0, 32'd0, 32'h0000_0200, 32'd0, tr);
      fetch(0, $urandom, 1'b0);

      // long memory stall with retire pulsed while waiting
      do_retire(2'd0, 1'b0, 32'd0, 32'd0, 32'd0, tr);
      fetch(5, 32'h00A0_0513, 1'b1);

      // pc wrap
      do_retire(2'd1, 1'b1, 32'hFFFF_FFFC, 32'd0, 32'd0, tr);
      fetch(0, $urandom, 1'b0);
      do_retire(2'd0, 1'b0, 32'd0, 32'd0, 32'd0, tr);
      check("wrap_pc", m_pc, 32'd0);
      fetch(0, $urandom, 1'b0);

      // misaligned branch target
      do_retire(2'd1, 1'b1, 32'h0000_0042, 32'd0, 32'd0, tr);
`ifdef FETCH_MISALIGN_TRAP_EN
      repeat (3) tick();
      check("trap_sticky", {31'b0, misalign_trap}, 32'd1);
      check("trap_sticky_req", {31'b0, imem_req}, 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_pc = 32'd0;
`endif
      fetch(0, $urandom, 1'b0);

      // reset in the middle of a request, late valid after release
      do_retire(2'd0, 1'b0, 32'd0, 32'd0, 32'd0, tr);
      tick();
      check("pre_rst_req", {31'b0, imem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_req", {31'b0, imem_req}, 32'd0);
      check("arst_pc", pc, 32'd0);
      check("arst_instr", instr, 32'h0000_0013);
      check("arst_iv", {31'b0, instr_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_valid = 1'b0;
      check("late_valid_instr", instr, 32'h0000_0013);
      check("late_valid_iv", {31'b0, instr_valid}, 32'd0);
      m_pc = 32'd0;
      fetch(1, 32'h0010_0093, 1'b0);

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         do_retire(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom & amask,
                   $urandom & amask, $urandom & (amask | 32'h1), tr);
         fetch($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
